// File: rtl/jamma_input_scheduler_pkg.sv
// Shared types and constants for the JAMMA input scheduler.
// Package: jamma_pkg
//   scan_state_e  : splitter scan FSM states
//   JOY_RELEASED  : idle (all released) active-low joystick word
//   COIN_RELEASED : idle active-low coin word
package jamma_pkg;

  localparam int unsigned JOY_W     = 8;
  localparam int unsigned COIN_W    = 2;
  localparam int unsigned LOCAL_W   = 6;
  localparam int unsigned SETTLE_W  = 8;
  localparam int unsigned DEB_CNT_W = 4;

  localparam logic [JOY_W-1:0]  JOY_RELEASED  = 8'hFF;
  localparam logic [COIN_W-1:0] COIN_RELEASED = 2'b11;

  typedef enum logic [1:0] {
    SETTLE_P1 = 2'd0,
    SAMPLE_P1 = 2'd1,
    SETTLE_P2 = 2'd2,
    SAMPLE_P2 = 2'd3
  } scan_state_e;

  // Settle counter load value: a settle state lasts exactly 'cycles' enabled cycles.
  function automatic logic [SETTLE_W-1:0] settle_load(input int unsigned cycles);
    return SETTLE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/jamma_input_scheduler_if.sv
// Splitter-side and core-side signals of the JAMMA input scheduler.
//   jjoy        : shared splitter bus, active-low, valid for selected player
//   jcoin       : coin switches, active-low
//   local_joy   : on-board DB9 joystick, active-low
//   jselect     : splitter select (0 = P1, 1 = P2)
//   joystick1/2 : debounced player words, active-low
//   coin        : debounced coin level, active-low
//   frame_valid : one-cycle pulse per completed P1+P2 scan
// Modports: master = scheduler, slave = board/core environment.
interface jamma_input_scheduler_if;
  import jamma_pkg::*;

  logic [JOY_W-1:0]   jjoy;
  logic [COIN_W-1:0]  jcoin;
  logic [LOCAL_W-1:0] local_joy;
  logic               jselect;
  logic [JOY_W-1:0]   joystick1;
  logic [JOY_W-1:0]   joystick2;
  logic [COIN_W-1:0]  coin;
  logic               frame_valid;

  modport master (
    input  jjoy, jcoin, local_joy,
    output jselect, joystick1, joystick2, coin, frame_valid
  );

  modport slave (
    output jjoy, jcoin, local_joy,
    input  jselect, joystick1, joystick2, coin, frame_valid
  );

endinterface

// File: rtl/jamma_input_scheduler_debounce.sv
// Per-channel sample debouncer: q follows raw once DEBOUNCE_SAMPLES
// consecutive identical samples have been seen.
//   pclk, Reset_n : clock, async active-low reset
//   sample_en     : one-cycle strobe, raw is captured on this edge
//   raw           : sampled word
//   q             : debounced word, resets to all-ones (released)
module jamma_debounce
  import jamma_pkg::*;
#(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic             pclk,
  input  logic             Reset_n,
  input  logic             sample_en,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] q
);

  localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEBOUNCE_SAMPLES);

  logic [WIDTH-1:0]     cand_q;
  logic [DEB_CNT_W-1:0] cnt_q;
  logic [DEB_CNT_W-1:0] new_cnt_c;

  // Run length including this sample, saturating at the threshold.
  always_comb begin
    new_cnt_c = DEB_CNT_W'(1);
    if (raw == cand_q) begin
      new_cnt_c = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + DEB_CNT_W'(1);
    end
  end

  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      cand_q <= '1;
      cnt_q  <= '0;
      q      <= '1;
    end else if (sample_en) begin
      cand_q <= raw;
      cnt_q  <= new_cnt_c;
      if (new_cnt_c >= CNT_MAX) begin
        q <= raw;
      end
    end
  end

endmodule

// File: rtl/jamma_input_scheduler.sv
// Time-multiplexed JAMMA splitter scheduler: alternates jselect between
// players, waits SETTLE_CYCLES after each switch, samples the shared bus
// for one cycle and debounces P1, P2 and coin words.
//   pclk    : pixel clock
//   Reset_n : async active-low reset
//   enable  : scan advance enable; low freezes everything, frame_valid low
//   bus     : jamma_input_scheduler_if.master (splitter + core signals)
// Optional: JOY_P1_LOCAL_MERGE_EN merges local_joy into the P1 sample.
module jamma_input_scheduler
  import jamma_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES    = 8,
  parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
  input  logic                   pclk,
  input  logic                   Reset_n,
  input  logic                   enable,
  jamma_input_scheduler_if.master bus
);

  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = settle_load(SETTLE_CYCLES);

  scan_state_e         state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic                jselect_q, jselect_d;
  logic                frame_valid_q, frame_valid_d;
  logic                sample_p1_c;
  logic                sample_p2_c;
  logic [JOY_W-1:0]    p1_raw_c;

  // Scan FSM state and registered outputs.
  always_ff @(posedge pclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= SETTLE_P1;
      settle_cnt_q  <= SETTLE_LOAD;
      jselect_q     <= 1'b0;
      frame_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      jselect_q     <= jselect_d;
      frame_valid_q <= frame_valid_d;
    end
  end

  // Next state; everything holds when enable is low.
  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    jselect_d     = jselect_q;
    frame_valid_d = 1'b0;
    sample_p1_c   = 1'b0;
    sample_p2_c   = 1'b0;

    if (enable) begin
      unique case (state_q)
        SETTLE_P1: begin
          if (settle_cnt_q == '0) begin
            state_d = SAMPLE_P1;
          end else begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          end
        end
        SAMPLE_P1: begin
          sample_p1_c  = 1'b1;
          state_d      = SETTLE_P2;
          settle_cnt_d = SETTLE_LOAD;
          jselect_d    = 1'b1;
        end
        SETTLE_P2: begin
          if (settle_cnt_q == '0) begin
            state_d = SAMPLE_P2;
          end else begin
            settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
          end
        end
        SAMPLE_P2: begin
          sample_p2_c   = 1'b1;
          state_d       = SETTLE_P1;
          settle_cnt_d  = SETTLE_LOAD;
          jselect_d     = 1'b0;
          frame_valid_d = 1'b1;
        end
        default: begin
          state_d      = SETTLE_P1;
          settle_cnt_d = SETTLE_LOAD;
          jselect_d    = 1'b0;
        end
      endcase
    end
  end

  // P1 raw word, optionally merged with the on-board joystick (active-low AND).
`ifdef JOY_P1_LOCAL_MERGE_EN
  assign p1_raw_c = bus.jjoy & {2'b11, bus.local_joy};
`else
  logic unused_local_joy;
  assign unused_local_joy = ^bus.local_joy;
  assign p1_raw_c = bus.jjoy;
`endif

  jamma_debounce #(
    .WIDTH            (JOY_W),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
  ) u_deb_p1 (
    .pclk      (pclk),
    .Reset_n   (Reset_n),
    .sample_en (sample_p1_c),
    .raw       (p1_raw_c),
    .q         (bus.joystick1)
  );

  jamma_debounce #(
    .WIDTH            (JOY_W),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
  ) u_deb_p2 (
    .pclk      (pclk),
    .Reset_n   (Reset_n),
    .sample_en (sample_p2_c),
    .raw       (bus.jjoy),
    .q         (bus.joystick2)
  );

  jamma_debounce #(
    .WIDTH            (COIN_W),
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
  ) u_deb_coin (
    .pclk      (pclk),
    .Reset_n   (Reset_n),
    .sample_en (sample_p2_c),
    .raw       (bus.jcoin),
    .q         (bus.coin)
  );

  assign bus.jselect     = jselect_q;
  assign bus.frame_valid = frame_valid_q;

endmodule
